// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
//
// A 32-step sequential engine. Multiply is shift-add on operand magnitudes
// into a 64-bit product; divide is restoring shift-subtract on magnitudes.
// Signs are applied once on the final step, so every op (special cases
// included) has the same latency: done is high in the cycle after the
// 32nd RUN edge.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   operation request (ignored while busy)
//   funct3  in   000 MUL 001 MULH 010 MULHSU 011 MULHU
//                100 DIV 101 DIVU 110 REM    111 REMU
//   op_a    in   rs1 operand
//   op_b    in   rs2 operand
//   wa      in   destination register address
//   flush   in   synchronous kill, priority over start
//   busy    out  high in RUN and DONE
//   stall   out  pipeline hold request
//   done    out  one-cycle result-valid strobe
//   result  out  final result, held until the next done
//   wa_out  out  destination address of the completed op
//
// state  | meaning
// -------+----------------------------------------------------
// IDLE   | waiting for start; start & ~flush launches an op
// RUN    | one iteration per edge, 32 edges (count 0..31)
// DONE   | result valid for one cycle, then back to IDLE
module ex_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  wa,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  wa_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [4:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [31:0] r_opnd;     // multiplicand (mul) or divisor (div) magnitude
  logic [63:0] r_work;     // mul: {partial hi, multiplier}; div: {rem, quotient}
  logic        r_neg;      // final result must be negated
  logic        r_b_zero;
  logic [31:0] r_result;
  logic [4:0]  r_wa_out;
  logic [4:0]  r_wa;

  logic        w_accept;
  logic        w_finish;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_neg;
  logic [32:0] w_sum;
  logic [63:0] w_mul_nxt;
  logic [32:0] w_shift;
  logic [33:0] w_diff;
  logic [63:0] w_div_nxt;
  logic [63:0] w_work_nxt;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_result_nxt;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    stall       = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          w_state_nxt = S_RUN;
          stall       = 1'b1;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        stall = 1'b1;
        if (flush)                w_state_nxt = S_IDLE;
        else if (r_cnt == 5'd31)  w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_finish = (r_state == S_RUN) && !flush && (r_cnt == 5'd31);

  // ------------------------------------------------- operand preparation
  // op_a is unsigned only for MULHU/DIVU/REMU; op_b additionally for MULHSU.
  assign w_a_signed = !((funct3 == 3'b011) || (funct3 == 3'b101) || (funct3 == 3'b111));
  assign w_b_signed = w_a_signed && (funct3 != 3'b010);
  assign w_a_neg    = w_a_signed && op_a[31];
  assign w_b_neg    = w_b_signed && op_b[31];
  assign w_a_mag    = w_a_neg ? (32'd0 - op_a) : op_a;
  assign w_b_mag    = w_b_neg ? (32'd0 - op_b) : op_b;
  // Remainder follows the dividend; product and quotient follow the xor.
  assign w_neg      = (funct3[2] && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  // ------------------------------------------------------- one iteration
  assign w_sum     = {1'b0, r_work[63:32]} + {1'b0, r_opnd};
  assign w_mul_nxt = r_work[0] ? {w_sum, r_work[31:1]} : {1'b0, r_work[63:1]};

  // Shifted remainder can reach 33 bits; compare in 34 bits so the sign
  // bit of the difference is a clean borrow.
  assign w_shift   = {r_work[63:32], r_work[31]};
  assign w_diff    = {1'b0, w_shift} - {2'b00, r_opnd};
  assign w_div_nxt = w_diff[33] ? {w_shift[31:0], r_work[30:0], 1'b0}
                                : {w_diff[31:0],  r_work[30:0], 1'b1};

  assign w_work_nxt = r_funct3[2] ? w_div_nxt : w_mul_nxt;

  // --------------------------------------------------- final sign fix-up
  assign w_prod_fix = r_neg ? (64'd0 - w_work_nxt) : w_work_nxt;
  assign w_quo_fix  = r_neg ? (32'd0 - w_work_nxt[31:0])  : w_work_nxt[31:0];
  assign w_rem_fix  = r_neg ? (32'd0 - w_work_nxt[63:32]) : w_work_nxt[63:32];

  always_comb begin
    w_result_nxt = 32'd0;
    case (r_funct3)
      3'b000:                 w_result_nxt = w_prod_fix[31:0];
      3'b001, 3'b010, 3'b011: w_result_nxt = w_prod_fix[63:32];
      // x/0 naturally yields an all-ones magnitude, but the sign fix-up
      // would corrupt it for negative dividends, so force it here.
      3'b100, 3'b101:         w_result_nxt = r_b_zero ? 32'hFFFF_FFFF : w_quo_fix;
      default:                w_result_nxt = w_rem_fix;
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 5'd0;
      r_funct3 <= 3'd0;
      r_opnd   <= 32'd0;
      r_work   <= 64'd0;
      r_neg    <= 1'b0;
      r_b_zero <= 1'b0;
      r_wa     <= 5'd0;
      r_result <= 32'd0;
      r_wa_out <= 5'd0;
    end else if (w_accept) begin
      r_cnt    <= 5'd0;
      r_funct3 <= funct3;
      r_opnd   <= funct3[2] ? w_b_mag : w_a_mag;
      r_work   <= {32'd0, (funct3[2] ? w_a_mag : w_b_mag)};
      r_neg    <= w_neg;
      r_b_zero <= (op_b == 32'd0);
      r_wa     <= wa;
    end else if (r_state == S_RUN) begin
      if (flush) begin
        r_cnt <= 5'd0;
      end else begin
        r_work <= w_work_nxt;
        if (w_finish) begin
          r_cnt    <= 5'd0;
          r_result <= w_result_nxt;
          r_wa_out <= r_wa;
        end else begin
          r_cnt <= r_cnt + 5'd1;
        end
      end
    end
  end

  assign result = r_result;
  assign wa_out = r_wa_out;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  wa;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  wa_out;

  int vectors = 0;
  int errs    = 0;

  logic [31:0] last_res = 32'd0;
  logic [4:0]  last_wa  = 5'd0;

  ex_muldiv dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .wa     (wa),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result),
    .wa_out (wa_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Reference: RV32M semantics computed with wide integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    longint      sp;
    logic [63:0] up;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    model = 32'd0;
    case (f3)
      3'd0: begin sp = sa * sb; p = sp; model = p[31:0];  end
      3'd1: begin sp = sa * sb; p = sp; model = p[63:32]; end
      3'd2: begin sp = sa * ub; p = sp; model = p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; model = up[63:32]; end
      3'd4: begin
        if (b == 32'd0) model = 32'hFFFF_FFFF;
        else begin sp = sa / sb; p = sp; model = p[31:0]; end
      end
      3'd5: model = (b == 32'd0) ? 32'hFFFF_FFFF : (a / b);
      3'd6: begin
        if (b == 32'd0) model = a;
        else begin sp = sa % sb; p = sp; model = p[31:0]; end
      end
      default: model = (b == 32'd0) ? a : (a % b);
    endcase
  endfunction

  // Called at a falling edge with the DUT idle; returns at a falling edge
  // one cycle after done.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] w, input logic [31:0] exp);
    int cyc;
    int bad;
    funct3 = f3; op_a = a; op_b = b; wa = w; start = 1'b1;
    #1;
    check({tag, ".stall_req"}, stall, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    bad = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (stall !== 1'b1 || busy !== 1'b1) bad++;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check({tag, ".latency"}, cyc, 32);
    check({tag, ".stall_run"}, bad, 0);
    check({tag, ".stall_done"}, stall, 1'b0);
    check({tag, ".result"}, result, exp);
    check({tag, ".wa_out"}, wa_out, w);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".idle"}, {busy, done, stall}, 3'b000);
    check({tag, ".hold"}, result, exp);
    last_res = exp;
    last_wa  = w;
  endtask

  initial begin
    int          n;
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] cap;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; wa = 5'd0;
    #3;
    check("reset.ctl", {busy, stall, done}, 3'b000);
    check("reset.result", result, 32'd0);
    check("reset.wa_out", wa_out, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op("mul",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFEB);
    run_op("mulh",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000);
    run_op("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE);
    run_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF);
    run_op("div",     3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD);
    run_op("rem",     3'd6, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFF);
    run_op("divu",    3'd5, 32'd100,       32'd7,         5'd6,  32'd14);
    run_op("remu",    3'd7, 32'd100,       32'd7,         5'd7,  32'd2);
    run_op("div0",    3'd4, 32'hFFFF_FF00, 32'd0,         5'd8,  32'hFFFF_FFFF);
    run_op("remu0",   3'd7, 32'd5,         32'd0,         5'd10, 32'd5);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);

    // Flush at RUN step 10
    funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; wa = 5'd30; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush.ctl", {busy, stall, done}, 3'b000);
    check("flush.result", result, last_res);
    check("flush.wa_out", wa_out, last_wa);
    n = 0;
    repeat (40) begin @(posedge clk); @(negedge clk); if (done === 1'b1) n++; end
    check("flush.no_done", n, 0);
    run_op("after_flush", 3'd5, 32'd1000, 32'd3, 5'd30, 32'd333);

    // start held high through RUN and DONE
    funct3 = 3'd0; op_a = 32'd12345; op_b = 32'd678; wa = 5'd17; start = 1'b1;
    n = 0;
    cap = 32'd0;
    repeat (80) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        n++;
        cap = result;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("held.done_count", n, 1);
    check("held.result", cap, model(3'd0, 32'd12345, 32'd678));
    last_res = cap;
    last_wa  = 5'd17;

    // Reset pulsed mid-RUN
    funct3 = 3'd1; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; wa = 5'd21; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) begin @(posedge clk); @(negedge clk); end
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.ctl", {busy, stall, done}, 3'b000);
    check("rst_mid.result", result, 32'd0);
    check("rst_mid.wa_out", wa_out, 5'd0);
    n = 0;
    repeat (3) begin @(negedge clk); if (done === 1'b1) n++; end
    check("rst_mid.no_done", n, 0);
    rst_n = 1'b1;
    // first start right after release is accepted at the first edge
    run_op("post_rst", 3'd7, 32'd77, 32'd10, 5'd22, 32'd7);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, 5'($urandom_range(0, 31)),
             model(rf, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
